multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Parametrised multicycle control unit for the MIPS-subset core; successor to the single-toggle decode controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes: PC, IR, register file, memory, ALU and I/O.
- Memory and I/O accesses stall on handshakes, or use a fixed latency counter.
- Sits between the instruction register and datapath; the datapath is unchanged apart from the new strobes.

Parameters:
- IO_EN, 1, 1 = decode IN (opcode 011010) and OUT (opcode 011011); 0 = these opcodes are illegal.
- MEM_HS, 1, 1 = MEM and FETCH wait for mem_ready; 0 = wait a fixed MEM_LAT cycles.
- MEM_LAT, 1, fixed memory latency in cycles (1..15); used only when MEM_HS=0.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- inst  in  32  IR contents; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  memory access complete (MEM_HS=1).
- io_ready  in  1  I/O port accepted/produced a word.
- pc_we  out  1  PC write enable.
- pc_src  out  2  00 = pc+4, 01 = branch target, 10 = jump target.
- ir_we  out  1  IR write enable.
- mem_re  out  1  memory read.
- mem_we  out  1  memory write.
- reg_we  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = I/O input.
- alu_src  out  1  0 = rt register, 1 = immediate.
- alu_func  out  6  ALU function code.
- zors  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend.
- in_gof  out  1  I/O read strobe.
- out_gof  out  1  I/O write strobe.
- illegal  out  1  sticky illegal-opcode flag.
- state  out  3  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Reset: rstn low at a clk edge sets state=FETCH, wait counter=0, illegal=0. While rstn is low, every strobe is forced to 0. Reset overrides any in-progress access.
- FETCH:
  - mem_re=1 every cycle.
  - On completion (mem_ready=1, or counter==MEM_LAT-1): ir_we=1, pc_we=1, pc_src=00, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: always 1 cycle; decodes inst[31:26].
  - j (000010): pc_we=1, pc_src=10, next FETCH.
  - Unknown opcode, or IN/OUT with IO_EN=0: illegal<=1, next HALT.
  - All other opcodes: next EXEC.
- EXEC, ALU instructions:
  - R-type (000000): alu_func=inst[5:0], alu_src=0.
  - addi 001000: alu_func=100000, zors=1.
  - andi 001100: alu_func=100100, zors=0.
  - ori 001101: alu_func=100101, zors=0.
  - slti 001010: alu_func=101010, zors=1.
  - Immediates use alu_src=1. Next state WB.
- EXEC, memory: lw 100011 / sw 101011 use alu_func=100000, alu_src=1, zors=1. Next state MEM.
- EXEC, branches: beq 000100 / bne 000101 use alu_func=100010, alu_src=0, zors=1.
  - Taken when beq and alu_zero=1, or bne and alu_zero=0: pc_we=1, pc_src=01.
  - Next state FETCH.
- EXEC, IN/OUT: in_gof (IN) or out_gof (OUT) held high until io_ready=1, then deasserted.
  - IN then goes to WB; OUT goes to FETCH.
- MEM:
  - lw: mem_re=1. sw: mem_we=1.
  - Held until completion, same rule as FETCH.
  - lw then goes to WB; sw goes to FETCH.
- WB: reg_we=1 for exactly 1 cycle, then FETCH.
  - reg_dst=1 for R-type only.
  - wb_sel: 01 for lw, 10 for IN, 00 otherwise.
- HALT: terminal; all strobes 0; exit only via reset.
- Default outputs: all strobes 0 and alu_func=000000 outside the cases above.
- Latency counter:
  - 4 bits; clears on entry to FETCH/MEM and on completion; saturates at 15.
  - MEM_LAT=1 means completion in the first cycle of the state.
- Simultaneous events: mem_ready already high on FETCH/MEM entry completes in that cycle. mem_ready outside FETCH/MEM is ignored.
- Cycle counts with zero wait:
  - R-type/imm: 4. lw: 5. sw: 4. Branch: 3. j: 2.

Test Plan:
- Reset mid-MEM of sw, with rstn low 1 cycle -> mem_we=0 that cycle; next cycle state=FETCH, mem_re=1, illegal=0.
- add (funct 100000) with mem_ready tied 1 -> states 0,1,2,4,0; alu_func=100000 in EXEC; reg_we=1, reg_dst=1 for exactly the WB cycle.
- lw with MEM_HS=1 and mem_ready delayed 3 cycles in MEM -> mem_re held 4 cycles; then WB with wb_sel=01; total 8 cycles.
- beq with alu_zero=1, then bne with alu_zero=1 -> first gives pc_we=1, pc_src=01 in EXEC; second gives pc_we=0; both return to FETCH.
- MEM_HS=0, MEM_LAT=3, mem_ready held 0 -> FETCH lasts exactly 3 cycles; ir_we pulses on cycle 3.
- opcode 011010 with IO_EN=0 -> illegal=1 after DECODE; state=7; strobes stay 0 for 20 cycles until rstn is pulsed.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle control unit for the MIPS-subset core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes, stalling on memory/I-O handshakes.
module multicycle_controller #(
  parameter bit          IO_EN   = 1'b1,
  parameter bit          MEM_HS  = 1'b1,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst,
  input  logic        alu_zero,
  input  logic        mem_ready,
  input  logic        io_ready,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic        reg_dst,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic [5:0]  alu_func,
  output logic        zors,
  output logic        in_gof,
  output logic        out_gof,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_IN    = 6'b011010;
  localparam logic [5:0] OP_OUT   = 6'b011011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       illegal_q, set_illegal;
  logic       mem_done, op_legal, br_taken;
  logic [5:0] opcode;
  logic       unused_inst_bits;

  assign opcode           = inst[31:26];
  assign unused_inst_bits = ^inst[25:6];
  assign mem_done         = MEM_HS ? mem_ready : (cnt_q == LAT_LAST);
  assign br_taken         = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: op_legal = 1'b1;
      OP_IN, OP_OUT:                 op_legal = IO_EN;
      default:                       op_legal = 1'b0;
    endcase
  end

  // NOTE: every output of this block is given a default before any branch, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'b00;
    ir_we       = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    wb_sel      = 2'b00;
    alu_src     = 1'b0;
    alu_func    = 6'b000000;
    zors        = 1'b0;
    in_gof      = 1'b0;
    out_gof     = 1'b0;
    // Reset silences every strobe even mid-access; the registers clear on the edge.
    if (rstn) begin
      case (state_q)
        S_FETCH: begin
          mem_re = 1'b1;
          if (mem_done) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!op_legal) begin
            set_illegal = 1'b1;
            state_d     = S_HALT;
          end else if (opcode == OP_J) begin
            pc_we   = 1'b1;
            pc_src  = 2'b10;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin alu_func = inst[5:0]; state_d = S_WB; end
            OP_ADDI:  begin alu_func = 6'b100000; alu_src = 1'b1; zors = 1'b1; state_d = S_WB; end
            OP_ANDI:  begin alu_func = 6'b100100; alu_src = 1'b1; state_d = S_WB; end
            OP_ORI:   begin alu_func = 6'b100101; alu_src = 1'b1; state_d = S_WB; end
            OP_SLTI:  begin alu_func = 6'b101010; alu_src = 1'b1; zors = 1'b1; state_d = S_WB; end
            OP_LW, OP_SW: begin
              alu_func = 6'b100000;
              alu_src  = 1'b1;
              zors     = 1'b1;
              state_d  = S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              alu_func = 6'b100010;
              zors     = 1'b1;
              pc_we    = br_taken;
              pc_src   = br_taken ? 2'b01 : 2'b00;
              state_d  = S_FETCH;
            end
            OP_IN: begin
              in_gof = 1'b1;
              if (io_ready) state_d = S_WB;
            end
            OP_OUT: begin
              out_gof = 1'b1;
              if (io_ready) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_re = (opcode == OP_LW);
          mem_we = (opcode == OP_SW);
          if (mem_done) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_we  = 1'b1;
          reg_dst = (opcode == OP_RTYPE);
          wb_sel  = (opcode == OP_LW) ? 2'b01 : (opcode == OP_IN) ? 2'b10 : 2'b00;
          state_d = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      // Counter is idle (zero) outside FETCH/MEM, so clearing on completion also covers entry.
      if ((state_q == S_FETCH || state_q == S_MEM) && !mem_done)
        cnt_q <= (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      else
        cnt_q <= 4'd0;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds the expected per-cycle trace of each instruction
// from the instruction-level rules and compares it against a handshake and a fixed-latency instance.
module tb_multicycle_controller;

  localparam int LAT_B = 3;
  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_H = 3'd7;
  localparam logic [23:0] STROBE_MASK = 24'h0F_FFFF;

  typedef struct packed {
    logic [2:0] state;
    logic       illegal;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic       reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic [5:0] alu_func;
    logic       zors;
    logic       in_gof;
    logic       out_gof;
  } obs_t;

  typedef struct {
    logic        rstn;
    logic [31:0] ins;
    logic        z;
    logic        mr;
    logic        ir;
    obs_t        exp;
    string       tag;
  } rec_t;

  typedef enum int {K_R, K_J, K_BR, K_IMM, K_LW, K_SW, K_IN, K_OUT, K_BAD} kind_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, rstn_b, alu_zero_a, alu_zero_b, mem_ready_a, mem_ready_b, io_ready_a, io_ready_b;
  logic [31:0] inst_a, inst_b;
  logic        pc_we_a, ir_we_a, mem_re_a, mem_we_a, reg_we_a, reg_dst_a, alu_src_a, zors_a;
  logic        in_gof_a, out_gof_a, illegal_a;
  logic [1:0]  pc_src_a, wb_sel_a;
  logic [5:0]  alu_func_a;
  logic [2:0]  state_a;
  logic        pc_we_b, ir_we_b, mem_re_b, mem_we_b, reg_we_b, reg_dst_b, alu_src_b, zors_b;
  logic        in_gof_b, out_gof_b, illegal_b;
  logic [1:0]  pc_src_b, wb_sel_b;
  logic [5:0]  alu_func_b;
  logic [2:0]  state_b;

  multicycle_controller #(.IO_EN(1'b1), .MEM_HS(1'b1), .MEM_LAT(1)) dut_a (
    .clk(clk), .rstn(rstn_a), .inst(inst_a), .alu_zero(alu_zero_a), .mem_ready(mem_ready_a),
    .io_ready(io_ready_a), .pc_we(pc_we_a), .pc_src(pc_src_a), .ir_we(ir_we_a), .mem_re(mem_re_a),
    .mem_we(mem_we_a), .reg_we(reg_we_a), .reg_dst(reg_dst_a), .wb_sel(wb_sel_a), .alu_src(alu_src_a),
    .alu_func(alu_func_a), .zors(zors_a), .in_gof(in_gof_a), .out_gof(out_gof_a),
    .illegal(illegal_a), .state(state_a)
  );

  multicycle_controller #(.IO_EN(1'b0), .MEM_HS(1'b0), .MEM_LAT(LAT_B)) dut_b (
    .clk(clk), .rstn(rstn_b), .inst(inst_b), .alu_zero(alu_zero_b), .mem_ready(mem_ready_b),
    .io_ready(io_ready_b), .pc_we(pc_we_b), .pc_src(pc_src_b), .ir_we(ir_we_b), .mem_re(mem_re_b),
    .mem_we(mem_we_b), .reg_we(reg_we_b), .reg_dst(reg_dst_b), .wb_sel(wb_sel_b), .alu_src(alu_src_b),
    .alu_func(alu_func_b), .zors(zors_b), .in_gof(in_gof_b), .out_gof(out_gof_b),
    .illegal(illegal_b), .state(state_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {state_a, illegal_a, pc_we_a, pc_src_a, ir_we_a, mem_re_a, mem_we_a, reg_we_a,
                  reg_dst_a, wb_sel_a, alu_src_a, alu_func_a, zors_a, in_gof_a, out_gof_a};
  assign obs_b = {state_b, illegal_b, pc_we_b, pc_src_b, ir_we_b, mem_re_b, mem_we_b, reg_we_b,
                  reg_dst_b, wb_sel_b, alu_src_b, alu_func_b, zors_b, in_gof_b, out_gof_b};

  int   errors = 0;
  int   checks = 0;
  bit   cur    = 1'b0;     // 0: dut_a (handshake, I/O on), 1: dut_b (fixed latency, I/O off)
  logic m_ill  = 1'b0;     // model of the sticky illegal flag
  rec_t plan[$];

  logic [5:0] ops [12] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                           6'h23, 6'h2B, 6'h1A, 6'h1B};

  function automatic bit cur_hs();
    return cur == 1'b0;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic obs_t base(logic [2:0] st);
    obs_t o = '0;
    o.state   = st;
    o.illegal = m_ill;
    return o;
  endfunction

  function automatic kind_t kind_of(logic [5:0] op);
    case (op)
      6'h00:                      return K_R;
      6'h02:                      return K_J;
      6'h04, 6'h05:               return K_BR;
      6'h08, 6'h0A, 6'h0C, 6'h0D: return K_IMM;
      6'h23:                      return K_LW;
      6'h2B:                      return K_SW;
      6'h1A:                      return (cur == 1'b0) ? K_IN : K_BAD;
      6'h1B:                      return (cur == 1'b0) ? K_OUT : K_BAD;
      default:                    return K_BAD;
    endcase
  endfunction

  function automatic logic [5:0] imm_func(logic [5:0] op);
    case (op)
      6'h08:   return 6'b100000;
      6'h0A:   return 6'b101010;
      6'h0C:   return 6'b100100;
      default: return 6'b100101;
    endcase
  endfunction

  // mem_ready for access cycle c of n: handshake completes on the last one; latency mode ignores it.
  function automatic logic mr_at(int c, int n, bit rnd);
    if (cur_hs()) return logic'(c == n - 1);
    return rnd ? rb() : 1'b0;
  endfunction

  task automatic push(input logic rstn, input logic [31:0] ins, input logic z, input logic mr,
                      input logic ir, input obs_t e, input string tag);
    rec_t r;
    r.rstn = rstn; r.ins = ins; r.z = z; r.mr = mr; r.ir = ir; r.exp = e; r.tag = tag;
    plan.push_back(r);
  endtask

  task automatic run_plan();
    rec_t        r;
    obs_t        got;
    logic [23:0] mask;
    while (plan.size() > 0) begin
      r = plan.pop_front();
      @(negedge clk);
      if (cur == 1'b0) begin
        rstn_a = r.rstn; inst_a = r.ins; alu_zero_a = r.z; mem_ready_a = r.mr; io_ready_a = r.ir;
      end else begin
        rstn_b = r.rstn; inst_b = r.ins; alu_zero_b = r.z; mem_ready_b = r.mr; io_ready_b = r.ir;
      end
      #1;
      got  = (cur == 1'b0) ? obs_a : obs_b;
      mask = r.rstn ? 24'hFF_FFFF : STROBE_MASK;
      checks++;
      assert ((got & mask) === (r.exp & mask)) else begin
        errors++;
        $error("FAIL %s dut=%0d: observed %h expected %h", r.tag, cur, got & mask, r.exp & mask);
      end
    end
  endtask

  task automatic reset_pulse();
    push(1'b0, 32'h0, 1'b0, rb(), rb(), '0, "reset");
    m_ill = 1'b0;
    run_plan();
  endtask

  task automatic do_halt(input int n);
    for (int c = 0; c < n; c++) push(1'b1, 32'h0, rb(), rb(), rb(), base(ST_H), "halt");
    reset_pulse();
  endtask

  // Expected trace of one instruction from the architectural rules, then driven and compared.
  task automatic do_instr(input logic [31:0] ins, input logic z, input int wf, input int wm,
                          input int wi, input bit rnd, input bit abort_mem);
    logic [5:0] op;
    kind_t      k;
    obs_t       e;
    int         n;
    op = ins[31:26];
    k  = kind_of(op);
    n  = cur_hs() ? wf + 1 : LAT_B;
    for (int c = 0; c < n; c++) begin
      e = base(ST_F);
      e.mem_re = 1'b1;
      if (c == n - 1) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
      push(1'b1, ins, z, mr_at(c, n, rnd), rb(), e, "fetch");
    end
    e = base(ST_D);
    if (k == K_J) begin
      e.pc_we = 1'b1; e.pc_src = 2'b10;
      push(1'b1, ins, z, rb(), rb(), e, "decode_j");
    end else if (k == K_BAD) begin
      push(1'b1, ins, z, rb(), rb(), e, "decode_bad");
      m_ill = 1'b1;
    end else begin
      push(1'b1, ins, z, rb(), rb(), e, "decode");
      e = base(ST_E);
      case (k)
        K_R:   e.alu_func = ins[5:0];
        K_IMM: begin
          e.alu_src  = 1'b1;
          e.alu_func = imm_func(op);
          e.zors     = (op == 6'h08 || op == 6'h0A);
        end
        K_LW, K_SW: begin e.alu_func = 6'b100000; e.alu_src = 1'b1; e.zors = 1'b1; end
        K_BR: begin
          e.alu_func = 6'b100010;
          e.zors     = 1'b1;
          if ((op == 6'h04 && z) || (op == 6'h05 && !z)) begin e.pc_we = 1'b1; e.pc_src = 2'b01; end
        end
        default: ;
      endcase
      if (k == K_IN || k == K_OUT) begin
        e.in_gof  = (k == K_IN);
        e.out_gof = (k == K_OUT);
        for (int c = 0; c <= wi; c++) push(1'b1, ins, z, rb(), logic'(c == wi), e, "exec_io");
      end else begin
        push(1'b1, ins, z, rb(), rb(), e, "exec");
      end
      if (k == K_LW || k == K_SW) begin
        n = cur_hs() ? wm + 1 : LAT_B;
        e = base(ST_M);
        e.mem_re = (k == K_LW);
        e.mem_we = (k == K_SW);
        if (abort_mem) begin
          for (int c = 0; c < wm; c++) push(1'b1, ins, z, 1'b0, rb(), e, "mem_wait");
          push(1'b0, ins, z, 1'b1, rb(), base(ST_M), "rst_mid_mem");
          m_ill = 1'b0;
        end else begin
          for (int c = 0; c < n; c++) push(1'b1, ins, z, mr_at(c, n, rnd), rb(), e, "mem");
        end
      end
      if (k == K_R || k == K_IMM || k == K_IN || (k == K_LW && !abort_mem)) begin
        e = base(ST_W);
        e.reg_we  = 1'b1;
        e.reg_dst = (k == K_R);
        e.wb_sel  = (k == K_LW) ? 2'b01 : (k == K_IN) ? 2'b10 : 2'b00;
        push(1'b1, ins, z, rb(), rb(), e, "wb");
      end
    end
    run_plan();
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  op;
    rstn_a = 1'b0; rstn_b = 1'b0; inst_a = '0; inst_b = '0;
    alu_zero_a = 1'b0; alu_zero_b = 1'b0; mem_ready_a = 1'b0; mem_ready_b = 1'b0;
    io_ready_a = 1'b0; io_ready_b = 1'b0;
    repeat (2) @(posedge clk);

    cur = 1'b0;
    reset_pulse();
    do_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 1'b0, 0, 0, 0, 1'b0, 1'b0);  // add
    do_instr({6'h23, 26'h0221_0004}, 1'b0, 0, 3, 0, 1'b0, 1'b0);                     // lw, 3 waits
    do_instr({6'h04, 26'h0000_0010}, 1'b1, 0, 0, 0, 1'b0, 1'b0);                     // beq taken
    do_instr({6'h05, 26'h0000_0010}, 1'b1, 0, 0, 0, 1'b0, 1'b0);                     // bne not taken
    do_instr({6'h05, 26'h0000_0010}, 1'b0, 2, 0, 0, 1'b0, 1'b0);                     // bne taken
    do_instr({6'h02, 26'h000_0100}, 1'b0, 1, 0, 0, 1'b0, 1'b0);                      // j
    do_instr({6'h2B, 26'h0041_0008}, 1'b0, 0, 2, 0, 1'b0, 1'b1);                     // sw, reset mid-MEM
    do_instr({6'h08, 26'h0022_FFFF}, 1'b0, 0, 0, 0, 1'b0, 1'b0);                     // addi
    do_instr({6'h0C, 26'h0022_00FF}, 1'b0, 0, 0, 0, 1'b0, 1'b0);                     // andi
    do_instr({6'h0D, 26'h0022_00FF}, 1'b0, 0, 0, 0, 1'b0, 1'b0);                     // ori
    do_instr({6'h0A, 26'h0022_8000}, 1'b0, 0, 0, 0, 1'b0, 1'b0);                     // slti
    do_instr({6'h1A, 26'h0003_0000}, 1'b0, 0, 0, 2, 1'b0, 1'b0);                     // IN
    do_instr({6'h1B, 26'h0003_0000}, 1'b0, 0, 0, 1, 1'b0, 1'b0);                     // OUT
    do_instr({6'h3F, 26'h0}, 1'b0, 0, 0, 0, 1'b0, 1'b0);                             // unknown opcode
    do_halt(5);
    for (int i = 0; i < 40; i++) begin
      r  = $urandom();
      op = ops[$urandom_range(0, 11)];
      do_instr({op, r[25:0]}, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'b1, 1'b0);
    end

    rstn_a = 1'b0;
    cur    = 1'b1;
    reset_pulse();
    do_instr({6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'b100010}, 1'b0, 0, 0, 0, 1'b0, 1'b0);  // 3-cycle fetch
    do_instr({6'h23, 26'h0221_0004}, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    do_instr({6'h2B, 26'h0221_0004}, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    do_instr({6'h1A, 26'h0003_0000}, 1'b0, 0, 0, 0, 1'b1, 1'b0);                     // IN is illegal here
    do_halt(20);
    for (int i = 0; i < 20; i++) begin
      r  = $urandom();
      op = ops[$urandom_range(0, 9)];
      do_instr({op, r[25:0]}, rb(), 0, 0, 0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
